// File: rtl/register_file_write_arbiter_if.sv
// register_file_write_arbiter_if: two writeback request channels in, register_file write port and pending status out
interface register_file_write_arbiter_if #(
  parameter int ADDRESS_WIDTH = 2,
  parameter int DATA_WIDTH    = 1
);
  logic                          request_0_valid;
  logic                          request_0_ready;
  logic [ADDRESS_WIDTH-1:0]      request_0_address;
  logic [DATA_WIDTH-1:0]         request_0_data;
  logic                          request_1_valid;
  logic                          request_1_ready;
  logic [ADDRESS_WIDTH-1:0]      request_1_address;
  logic [DATA_WIDTH-1:0]         request_1_data;
  logic                          general_register_write_enable;
  logic [ADDRESS_WIDTH-1:0]      address_3;
  logic [DATA_WIDTH-1:0]         general_register_write_data;
  logic [2**ADDRESS_WIDTH-1:0]   pending_mask;
  logic                          last_grant;
  modport slave (
    input  request_0_valid, request_0_address, request_0_data,
    input  request_1_valid, request_1_address, request_1_data,
    output request_0_ready, request_1_ready,
    output general_register_write_enable, address_3, general_register_write_data,
    output pending_mask, last_grant
  );
  modport master (
    output request_0_valid, request_0_address, request_0_data,
    output request_1_valid, request_1_address, request_1_data,
    input  request_0_ready, request_1_ready,
    input  general_register_write_enable, address_3, general_register_write_data,
    input  pending_mask, last_grant
  );
endinterface

// File: rtl/register_file_write_arbiter.sv
// register_file_write_arbiter: shares the register_file general write port between execute (0) and load (1)
// writeback, one holding entry each, oldest-first with round-robin tie-break, register 0 never written.
// Optional REGISTER_FILE_WRITE_ARBITER_STATS_EN adds an 8-bit saturating conflict_count output.
module register_file_write_arbiter #(
  parameter int ADDRESS_WIDTH = 2,
  parameter int DATA_WIDTH    = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  register_file_write_arbiter_if.slave       bus
`ifdef REGISTER_FILE_WRITE_ARBITER_STATS_EN
  ,
  output logic [7:0]                         conflict_count
`endif
);
  localparam int REGS = 2**ADDRESS_WIDTH;

  logic [1:0]               w_req_valid;
  logic [ADDRESS_WIDTH-1:0] w_req_address [2];
  logic [DATA_WIDTH-1:0]    w_req_data [2];
  logic [1:0]               w_hold_valid;
  logic [1:0]               w_hold_younger;
  logic [ADDRESS_WIDTH-1:0] w_hold_address [2];
  logic [DATA_WIDTH-1:0]    w_hold_data [2];
  logic [1:0]               w_accept;
  logic [1:0]               w_complete;
  logic                     w_grant;
  logic                     w_grant_valid;
  logic [ADDRESS_WIDTH-1:0] w_sel_address;
  logic [DATA_WIDTH-1:0]    w_sel_data;
  logic                     r_last_grant;

  assign w_req_valid      = {bus.request_1_valid, bus.request_0_valid};
  assign w_req_address[0] = bus.request_0_address;
  assign w_req_address[1] = bus.request_1_address;
  assign w_req_data[0]    = bus.request_0_data;
  assign w_req_data[1]    = bus.request_1_data;

  // grant selection: lone entry wins, else the older one, else the one not granted last time
  always_comb begin
    w_accept      = w_req_valid & ~w_hold_valid;
    w_grant_valid = |w_hold_valid;
    w_grant       = &w_hold_valid
                  ? ((w_hold_younger[0] != w_hold_younger[1]) ? w_hold_younger[0] : ~r_last_grant)
                  : w_hold_valid[1];
    w_complete    = w_grant_valid ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    w_sel_address = w_grant ? w_hold_address[1] : w_hold_address[0];
    w_sel_data    = w_grant ? w_hold_data[1] : w_hold_data[0];
  end

  for (genvar i = 0; i < 2; i++) begin : g_hold
    logic                     r_valid;
    logic                     r_younger;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0]    r_data;
    // capture on accept, drain on grant; an entry behind a still-waiting peer is the younger one
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        r_valid   <= 1'b0;
        r_younger <= 1'b0;
        r_address <= '0;
        r_data    <= '0;
      end else if (w_accept[i]) begin
        r_valid   <= 1'b1;
        r_younger <= w_hold_valid[1-i] & ~w_complete[1-i];
        r_address <= w_req_address[i];
        r_data    <= w_req_data[i];
      end else if (w_complete[i]) begin
        r_valid   <= 1'b0;
        r_younger <= 1'b0;
      end else if (w_complete[1-i])
        r_younger <= 1'b0;
    assign w_hold_valid[i]   = r_valid;
    assign w_hold_younger[i] = r_younger;
    assign w_hold_address[i] = r_address;
    assign w_hold_data[i]    = r_data;
  end

  // remember who drained last so equal-age contention alternates; starts at 1 so requester 0 wins first
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      r_last_grant <= 1'b1;
    else if (w_grant_valid)
      r_last_grant <= w_grant;

  assign bus.request_0_ready               = ~w_hold_valid[0];
  assign bus.request_1_ready               = ~w_hold_valid[1];
  assign bus.address_3                     = w_grant_valid ? w_sel_address : '0;
  assign bus.general_register_write_data   = w_grant_valid ? w_sel_data : '0;
  assign bus.general_register_write_enable = w_grant_valid & (w_sel_address != '0);
  assign bus.last_grant                    = r_last_grant;
  assign bus.pending_mask                  = ((REGS'(w_hold_valid[0]) << w_hold_address[0])
                                           |  (REGS'(w_hold_valid[1]) << w_hold_address[1]))
                                           & ~REGS'(1);

`ifdef REGISTER_FILE_WRITE_ARBITER_STATS_EN
  logic [7:0] r_conflict_count;
  // count edges with both entries waiting, saturating at 255
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      r_conflict_count <= '0;
    else if (&w_hold_valid && r_conflict_count != 8'hff)
      r_conflict_count <= r_conflict_count + 8'd1;
  assign conflict_count = r_conflict_count;
`endif
endmodule

// File: tb/tb_register_file_write_arbiter.sv
// tb_register_file_write_arbiter: directed vectors with a write scoreboard popped by a port monitor
module tb_register_file_write_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [2:0] exp_q [$];
  logic model [4] = '{default: 1'b0};

  register_file_write_arbiter_if #(.ADDRESS_WIDTH(2), .DATA_WIDTH(1)) bus ();

`ifdef REGISTER_FILE_WRITE_ARBITER_STATS_EN
  logic [7:0] conflict_count;
  register_file_write_arbiter #(.ADDRESS_WIDTH(2), .DATA_WIDTH(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .conflict_count(conflict_count));
`else
  register_file_write_arbiter #(.ADDRESS_WIDTH(2), .DATA_WIDTH(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic v, input logic [1:0] a, input logic d);
    bus.request_0_valid = v; bus.request_0_address = a; bus.request_0_data = d;
  endtask

  task automatic req1(input logic v, input logic [1:0] a, input logic d);
    bus.request_1_valid = v; bus.request_1_address = a; bus.request_1_data = d;
  endtask

  task automatic status(input string tag, input int en, input int a, input int d, input int mask,
                        input int r0, input int r1, input int lg);
    chk({tag, ".enable"}, int'(bus.general_register_write_enable), en);
    chk({tag, ".address_3"}, int'(bus.address_3), a);
    chk({tag, ".data"}, int'(bus.general_register_write_data), d);
    chk({tag, ".pending_mask"}, int'(bus.pending_mask), mask);
    chk({tag, ".ready0"}, int'(bus.request_0_ready), r0);
    chk({tag, ".ready1"}, int'(bus.request_1_ready), r1);
    chk({tag, ".last_grant"}, int'(bus.last_grant), lg);
  endtask

  // monitor: every write the port performs must be the next one the stimulus expected
  always @(negedge clk)
    if (reset_n && bus.general_register_write_enable) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=addr%0d/data%0d required=none",
                 bus.address_3, bus.general_register_write_data);
      end else
        chk("write{addr,data}", int'({bus.address_3, bus.general_register_write_data}),
            int'(exp_q.pop_front()));
      model[bus.address_3] = bus.general_register_write_data;
    end

  initial begin
    req0(1'b1, 2'd1, 1'b1);
    req1(1'b0, 2'd0, 1'b0);
    tick(); tick();
    status("in_reset", 0, 0, 0, 0, 1, 1, 1);
    req0(1'b0, 2'd0, 1'b0);
    reset_n = 1'b1;
    tick();
    status("idle", 0, 0, 0, 0, 1, 1, 1);

    req0(1'b1, 2'd1, 1'b1); exp_q.push_back({2'd1, 1'b1});
    tick(); req0(1'b0, 2'd0, 1'b0);
    status("single", 1, 1, 1, 4'b0010, 0, 1, 1);
    tick();
    status("single_done", 0, 0, 0, 0, 1, 1, 0);
    chk("reg1_after_single", int'(model[1]), 1);

    reset_n = 1'b0; tick(); reset_n = 1'b1;
    req0(1'b1, 2'd2, 1'b1); req1(1'b1, 2'd3, 1'b0);
    exp_q.push_back({2'd2, 1'b1}); exp_q.push_back({2'd3, 1'b0});
    tick(); req0(1'b0, 2'd0, 1'b0); req1(1'b0, 2'd0, 1'b0);
    status("tie_a", 1, 2, 1, 4'b1100, 0, 0, 1);
    tick();
    status("tie_b", 1, 3, 0, 4'b1000, 1, 0, 0);
    tick();
    status("tie_done", 0, 0, 0, 0, 1, 1, 1);
    chk("reg2_after_tie", int'(model[2]), 1);
    chk("reg3_after_tie", int'(model[3]), 0);
`ifdef REGISTER_FILE_WRITE_ARBITER_STATS_EN
    chk("conflict_after_tie", int'(conflict_count), 1);
`endif

    req0(1'b1, 2'd1, 1'b0); exp_q.push_back({2'd1, 1'b0});
    tick(); req0(1'b0, 2'd0, 1'b0);
    tick();
    status("rr_prep", 0, 0, 0, 0, 1, 1, 0);
    req0(1'b1, 2'd2, 1'b0); req1(1'b1, 2'd3, 1'b1);
    exp_q.push_back({2'd3, 1'b1}); exp_q.push_back({2'd2, 1'b0});
    tick(); req0(1'b0, 2'd0, 1'b0); req1(1'b0, 2'd0, 1'b0);
    status("rr_a", 1, 3, 1, 4'b1100, 0, 0, 0);
    tick();
    status("rr_b", 1, 2, 0, 4'b0100, 0, 1, 1);
    tick();

    req0(1'b1, 2'd1, 1'b1); exp_q.push_back({2'd1, 1'b1});
    tick(); req0(1'b0, 2'd0, 1'b0);
    req1(1'b1, 2'd2, 1'b0); exp_q.push_back({2'd2, 1'b0});
    tick(); req1(1'b0, 2'd0, 1'b0);
    status("age_a", 1, 2, 0, 4'b0100, 1, 0, 0);
    req0(1'b1, 2'd2, 1'b1); exp_q.push_back({2'd2, 1'b1});
    tick(); req0(1'b0, 2'd0, 1'b0);
    status("age_b", 1, 2, 1, 4'b0100, 0, 1, 1);
    tick();
    status("age_done", 0, 0, 0, 0, 1, 1, 0);
    chk("reg2_after_age", int'(model[2]), 1);

    req0(1'b1, 2'd0, 1'b1);
    tick(); req0(1'b0, 2'd0, 1'b0);
    status("zero", 0, 0, 1, 0, 0, 1, 0);
    tick();
    status("zero_done", 0, 0, 0, 0, 1, 1, 0);
    chk("reg0", int'(model[0]), 0);

    req0(1'b1, 2'd1, 1'b0); req1(1'b1, 2'd3, 1'b0);
    tick(); req0(1'b0, 2'd0, 1'b0); req1(1'b0, 2'd0, 1'b0);
    status("mid", 1, 3, 0, 4'b1010, 0, 0, 0);
`ifdef REGISTER_FILE_WRITE_ARBITER_STATS_EN
    chk("conflict_before_reset", int'(conflict_count), 2);
`endif
    #2 reset_n = 1'b0;
    #1 status("mid_reset", 0, 0, 0, 0, 1, 1, 1);
`ifdef REGISTER_FILE_WRITE_ARBITER_STATS_EN
    chk("conflict_after_reset", int'(conflict_count), 0);
`endif
    tick(); reset_n = 1'b1;
    tick(); tick();
    status("post_reset", 0, 0, 0, 0, 1, 1, 1);
    chk("reg1_final", int'(model[1]), 1);
    chk("reg3_final", int'(model[3]), 1);
    chk("writes_outstanding", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/register_file_write_arbiter.md
Name: register_file_write_arbiter

Overview:
- Shares the single general-register write port of `register_file` (`general_register_write_enable`, `address_3`, `general_register_write_data`) between two writeback requesters: requester 0 is the execute unit and requester 1 is the load unit.
- Each requester has a one-entry holding register.
- Arbitration is oldest-first, with a round-robin tie-break.
- A pending-write mask is exported so decode can stall reads of registers with an outstanding write.
- Sits between the writeback stages and `register_file`; the stack write port is not touched.

Parameters:
- ADDRESS_WIDTH, 2, register address width; matches `register_file` first parameter.
- DATA_WIDTH, 1, register data width; matches `register_file` second parameter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- request_0_valid  input  1  requester 0 has a write.
- request_0_ready  output  1  requester 0 may present a write.
- request_0_address  input  ADDRESS_WIDTH  destination register.
- request_0_data  input  DATA_WIDTH  write data.
- request_1_valid / request_1_ready / request_1_address / request_1_data  as above, for requester 1.
- general_register_write_enable  output  1  to `register_file`.
- address_3  output  ADDRESS_WIDTH  write address to `register_file`.
- general_register_write_data  output  DATA_WIDTH  write data to `register_file`.
- pending_mask  output  2**ADDRESS_WIDTH  bit k = a held write targets register k.
- last_grant  output  1  requester granted most recently.

Behaviour:
- **Reset.** Asynchronous, active-low, effective immediately, including mid-operation.
  - Clears both holding registers, age flags and `last_grant` (set to 1, so requester 0 wins the first tie).
  - Outputs during reset: `general_register_write_enable` = 0, `address_3` = 0, `general_register_write_data` = 0, `pending_mask` = 0, both readies = 1.
  - Held writes are discarded, never performed.
- **Ready and accept.**
  - `request_n_ready` = NOT hold_n_valid; it is a function of registered state only, with no combinational path from valid.
  - Accept happens on a rising clk edge where valid AND ready are both 1.
  - On accept, the hold captures address and data and sets `hold_n_valid`.
- **Age.**
  - On accept, if the other hold is already valid, this entry is marked younger.
  - If both requesters are accepted on the same edge, the entries have equal age.
- **Grant (combinational from holds).**
  - One hold valid: grant it.
  - Both valid, different ages: grant the older.
  - Both valid, equal ages: grant the requester NOT equal to `last_grant`.
- **Drive.**
  - The granted hold drives `address_3` and `general_register_write_data`.
  - `general_register_write_enable` = 1 when a hold is granted, except for address 0.
  - When no hold is valid: enable = 0; address and data are driven as 0.
- **Completion.**
  - On the next rising edge the granted hold clears and `last_grant` updates.
  - The ungranted hold, if any, becomes the older entry.
- **Latency.** A write accepted at edge N is driven during cycle N+1 if uncontested, and lands in the register file at edge N+1. A contested write lands one cycle later.
- **Throughput.** Each requester can issue at most one write every 2 cycles, because ready drops for the cycle its hold is draining. The total port rate is at most 1 write per cycle.
- **Register 0** is hardwired zero.
  - Writes to address 0 are accepted and granted normally but drive enable = 0.
  - Such writes consume a grant slot.
  - Such writes never set `pending_mask` bit 0.
- **`pending_mask`.**
  - Bit k = (hold_0_valid AND addr_0==k) OR (hold_1_valid AND addr_1==k), for k≠0.
  - The bit stays set until the completing edge.
- **Same address in both holds.** Ordering is by age; the register ends with the younger data. For a tie, round-robin order applies.

Optional Feature:
- Macro: `REGISTER_FILE_WRITE_ARBITER_STATS_EN`.
- With the macro defined:
  - Adds output `conflict_count`, 8 bits.
  - The counter increments on every edge where both holds are valid.
  - It saturates at 255 and clears on reset.
- Without the macro: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- **Reset:** `reset_n`=0 then released → enable=0, `pending_mask`=0, both readies=1. Hold `request_0_valid`=1 during reset → nothing is accepted.
- **Single write:** requester 0 writes addr 1, data 1, accepted at edge N → cycle N+1 shows enable=1, `address_3`=1, data=1, `pending_mask`=4'b0010. At edge N+1 the mask clears; register 1 reads back 1.
- **Simultaneous tie:** both requesters are accepted on the same edge (r0 addr 2, data 1; r1 addr 3, data 0) after reset → r0 is granted first (`last_grant`=0), r1 the next cycle. Registers read 2=1 and 3=0.
- **Age priority:** r1 is accepted at edge N (addr 2, data 0) while r0 is still being held; then r0 is accepted at edge N+1 (addr 2, data 1) → r1 is written first, then r0. Register 2 finally reads 1.
- **Address 0:** r0 writes addr 0, data 1 → enable stays 0, `pending_mask`=0, ready returns 2 cycles later. Register 0 reads 0.
- **Reset mid-operation:** both holds valid; assert `reset_n`=0 between edges → enable falls to 0 immediately and neither write lands. With stats enabled, `conflict_count` returns to 0.
